nios2_computer_led_sequencer: RTL and testbench

NIOS2_COMPUTER_LED_SEQUENCER -- requirements
Module: nios2_computer_led_sequencer

---
 rtl/nios2_computer_ledseq_pkg.sv | 36 +++
 rtl/nios2_computer_led_sequencer_if.sv | 25 ++
 rtl/nios2_computer_ledseq_tick.sv | 35 +++
 rtl/nios2_computer_led_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_nios2_computer_led_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_computer_ledseq_pkg.sv
// Shared definitions for the LED sequencer.
//   mode_e   : sequencing mode held in CTRL[2:1]
//   state_e  : sequencer FSM states
//   ADDR_*   : Avalon-MM word offsets
//   CTRL_* / STATUS_* : register bit positions
package nios2_computer_ledseq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_MODE_LSB   = 1;
    localparam int unsigned CTRL_MODE_MSB   = 2;
    localparam int unsigned CTRL_BRIGHT_LSB = 8;
    localparam int unsigned CTRL_BRIGHT_MSB = 11;

    localparam int unsigned STATUS_RUN_BIT  = 0;
    localparam int unsigned STATUS_STEP_LSB = 8;
    localparam int unsigned STATUS_STEP_MSB = 15;

endpackage

// File: rtl/nios2_computer_led_sequencer_if.sv
// Avalon-MM slave bus of the LED sequencer.
//   address    : word offset (CTRL, PATTERN, PERIOD, STATUS)
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data
//   readdata   : zero-latency read data
interface nios2_computer_led_sequencer_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios2_computer_ledseq_tick.sv
// Step prescaler: counts 0..period while run is high and pulses tick on
// the cycle the count equals period. Held at 0 when not running.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous return to 0
//   run        : count enable
//   period     : terminal count
//   tick       : step strobe (combinational)
module nios2_computer_ledseq_tick #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] cnt;

    assign tick = run && (cnt == period);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/nios2_computer_led_sequencer.sv
// LED sequencer with an Avalon-MM register interface.
//   clk, reset : clock, asynchronous active-high reset
//   avs        : Avalon-MM slave (CTRL/PATTERN/PERIOD/STATUS)
//   out_port   : LED drive
// Optional: define LEDSEQ_PWM_EN to add global brightness (CTRL[11:8]).
module nios2_computer_led_sequencer
    import nios2_computer_ledseq_pkg::*;
#(
    parameter int unsigned LED_W    = 8,
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                            clk,
    input  logic                            reset,
    nios2_computer_led_sequencer_if.slave   avs,
    output logic [LED_W-1:0]                out_port
);

    state_e              state;
    mode_e               mode;
    logic                ctrl_en;
    logic [LED_W-1:0]    pattern;
    logic [PERIOD_W-1:0] period;
    logic [LED_W-1:0]    work;
    logic [LED_W-1:0]    work_nx;
    logic                dir_right;
    logic                dir_nx;
    logic [7:0]          step;
    logic                tick;
    logic                running;
    logic [LED_W-1:0]    led_val;
`ifdef LEDSEQ_PWM_EN
    logic [3:0]          bright;
    logic [3:0]          pwm_cnt;
    logic                pwm_on;
`endif

    logic  wr, wr_ctrl, disable_wr, reload_wr;
    mode_e new_mode;
    logic  unused_wdata;

    assign wr         = avs.chipselect && !avs.write_n;
    assign wr_ctrl    = wr && (avs.address == ADDR_CTRL);
    assign new_mode   = mode_e'(avs.writedata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    assign disable_wr = wr_ctrl && !avs.writedata[CTRL_EN_BIT];
    // Any change to the sequence definition restarts it from PATTERN.
    assign reload_wr  = wr && ((avs.address == ADDR_PATTERN) ||
                               (avs.address == ADDR_PERIOD)  ||
                               (wr_ctrl && (new_mode != mode)));
    assign unused_wdata = ^avs.writedata;
    assign running    = (state == ST_RUN);

    nios2_computer_ledseq_tick #(.PERIOD_W(PERIOD_W)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_LOAD),
        .run    (running),
        .period (period),
        .tick   (tick)
    );

    // Register file writes; STATUS is read-only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en <= 1'b0;
            mode    <= MODE_STATIC;
            pattern <= '0;
            period  <= '0;
`ifdef LEDSEQ_PWM_EN
            bright  <= 4'hF;
`endif
        end else if (wr) begin
            case (avs.address)
                ADDR_CTRL: begin
                    ctrl_en <= avs.writedata[CTRL_EN_BIT];
                    mode    <= new_mode;
`ifdef LEDSEQ_PWM_EN
                    bright  <= avs.writedata[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB];
`endif
                end
                ADDR_PATTERN: pattern <= avs.writedata[LED_W-1:0];
                ADDR_PERIOD:  period  <= avs.writedata[PERIOD_W-1:0];
                default: ;
            endcase
        end
    end

    // Next work value for one step. BOUNCE reverses instead of losing a
    // set bit off the end, shifting once the other way in the same step.
    always_comb begin
        work_nx = work;
        dir_nx  = dir_right;
        unique case (mode)
            MODE_STATIC: work_nx = work;
            MODE_ROTATE: work_nx = {work[LED_W-2:0], work[LED_W-1]};
            MODE_BOUNCE: begin
                if (!dir_right) begin
                    if (work[LED_W-1]) begin
                        dir_nx  = 1'b1;
                        work_nx = work >> 1;
                    end else begin
                        work_nx = work << 1;
                    end
                end else begin
                    if (work[0]) begin
                        dir_nx  = 1'b0;
                        work_nx = work << 1;
                    end else begin
                        work_nx = work >> 1;
                    end
                end
            end
            MODE_BLINK:  work_nx = (work != '0) ? '0 : pattern;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            work      <= '0;
            dir_right <= 1'b0;
            step      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_en && !disable_wr) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    work      <= pattern;
                    dir_right <= 1'b0;
                    step      <= '0;
                    if (disable_wr)     state <= ST_IDLE;
                    else if (reload_wr) state <= ST_LOAD;
                    else                state <= ST_RUN;
                end
                ST_RUN: begin
                    // A disable write on a tick edge suppresses that step.
                    if (disable_wr) begin
                        state <= ST_IDLE;
                    end else begin
                        if (tick) begin
                            work      <= work_nx;
                            dir_right <= dir_nx;
                            step      <= step + 8'd1;
                        end
                        if (reload_wr) state <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_CTRL: begin
                avs.readdata[CTRL_EN_BIT]                   = ctrl_en;
                avs.readdata[CTRL_MODE_MSB:CTRL_MODE_LSB]   = mode;
`ifdef LEDSEQ_PWM_EN
                avs.readdata[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB] = bright;
`endif
            end
            ADDR_PATTERN: avs.readdata[LED_W-1:0]    = pattern;
            ADDR_PERIOD:  avs.readdata[PERIOD_W-1:0] = period;
            default: begin
                avs.readdata[STATUS_RUN_BIT]                  = running;
                avs.readdata[STATUS_STEP_MSB:STATUS_STEP_LSB] = step;
            end
        endcase
    end

    assign led_val = running ? work : pattern;

`ifdef LEDSEQ_PWM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 4'd1;
    end

    // 0xF is full on, so it cannot be a plain compare against the counter.
    assign pwm_on   = (bright == 4'hF) || (pwm_cnt < bright);
    assign out_port = led_val & {LED_W{pwm_on}};
`else
    assign out_port = led_val;
`endif

endmodule

// File: tb/tb_nios2_computer_led_sequencer.sv
module tb_nios2_computer_led_sequencer;

    localparam int unsigned LED_W    = 8;
    localparam int unsigned PERIOD_W = 24;
    localparam int unsigned LTOP     = 1 << LED_W;
    localparam logic [31:0] FULL     = 32'h0000_0F00;
`ifdef LEDSEQ_PWM_EN
    localparam logic [31:0] RST_CTRL = 32'h0000_0F00;
`else
    localparam logic [31:0] RST_CTRL = 32'h0;
`endif

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [LED_W-1:0] out_port;

    nios2_computer_led_sequencer_if bus ();

    nios2_computer_led_sequencer #(.LED_W(LED_W), .PERIOD_W(PERIOD_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (bus.slave),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sequencer described by phase flags and arithmetic.
    int unsigned m_pattern = 0, m_period = 0, m_work = 0, m_step = 0, m_cnt = 0;
    int unsigned m_mode = 0, m_bright = 15, m_pwm = 0;
    bit          m_en = 0, m_left = 1, m_loading = 0, m_running = 0;

    task automatic model_reset();
        m_pattern = 0; m_period = 0; m_work = 0; m_step = 0; m_cnt = 0;
        m_mode = 0; m_bright = 15; m_pwm = 0;
        m_en = 0; m_left = 1; m_loading = 0; m_running = 0;
    endtask

    task automatic model_clock(input bit wr, input int unsigned a, input bit [31:0] d);
        bit          tick = 0;
        bit          dis, rel;
        int unsigned nmode;
        nmode = (d >> 1) & 3;
        dis   = wr && a == 0 && d[0] == 1'b0;
        rel   = wr && (a == 1 || a == 2 || (a == 0 && d[0] && nmode != m_mode));
        if (m_running) begin
            tick  = (m_cnt == m_period);
            m_cnt = tick ? 0 : m_cnt + 1;
        end else begin
            m_cnt = 0;
        end
        if (m_running && tick && !dis) begin
            m_step = (m_step + 1) % 256;
            case (m_mode)
                1: m_work = ((m_work * 2) % LTOP) + m_work / (LTOP / 2);
                2: begin
                    if (m_left) begin
                        if (m_work >= LTOP / 2) begin m_left = 0; m_work = m_work / 2; end
                        else m_work = m_work * 2;
                    end else begin
                        if (m_work % 2 == 1) begin m_left = 1; m_work = (m_work * 2) % LTOP; end
                        else m_work = m_work / 2;
                    end
                end
                3: m_work = (m_work != 0) ? 0 : m_pattern;
                default: ;
            endcase
        end
        if (m_loading) begin
            m_work = m_pattern; m_step = 0; m_left = 1; m_cnt = 0;
        end
        if (dis) begin
            m_running = 0; m_loading = 0;
        end else if (!m_running && !m_loading) begin
            m_loading = m_en;
        end else if (rel) begin
            m_running = 0; m_loading = 1;
        end else if (m_loading) begin
            m_loading = 0; m_running = 1;
        end
        m_pwm = (m_pwm + 1) % 16;
        if (wr) begin
            case (a)
                0: begin m_en = d[0]; m_mode = nmode; m_bright = (d >> 8) & 15; end
                1: m_pattern = d % LTOP;
                2: m_period  = d & ((1 << PERIOD_W) - 1);
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_clock(bus.chipselect && !bus.write_n, bus.address, bus.writedata);
    end

    function automatic logic [31:0] exp_out();
        int unsigned v;
        v = m_running ? m_work : m_pattern;
`ifdef LEDSEQ_PWM_EN
        if (!(m_bright == 15 || m_pwm < m_bright)) v = 0;
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_rd(input int unsigned a);
        case (a)
`ifdef LEDSEQ_PWM_EN
            0: return m_en | (m_mode << 1) | (m_bright << 8);
`else
            0: return m_en | (m_mode << 1);
`endif
            1: return m_pattern;
            2: return m_period;
            default: return (m_running ? 1 : 0) | (m_step << 8);
        endcase
    endfunction

    always @(negedge clk) begin
        check("out_port", 32'(out_port), exp_out());
        check("readdata", bus.readdata, exp_rd(bus.address));
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #2;
        bus.address = a; #1;
        d = bus.readdata;
    endtask

    // Leaves the bench just after the first negedge with RUNNING=1.
    task automatic wait_running(input string name);
        bit seen = 0;
        bus.address = 2'd3;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            seen = bus.readdata[0];
        end
        check(name, 32'(seen), 32'd1);
    endtask

    logic [31:0] rd;
    logic [7:0]  seq [$];
    int          on_cnt;

    initial begin
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_out", 32'(out_port), 32'h0);
        read_reg(2'd0, rd); check("rst_ctrl", rd, RST_CTRL);
        read_reg(2'd1, rd); check("rst_pattern", rd, 32'h0);
        read_reg(2'd2, rd); check("rst_period", rd, 32'h0);
        read_reg(2'd3, rd); check("rst_status", rd, 32'h0);

        // ROTATE, one step every 4 clocks
        bus_write(2'd1, 32'h81);
        bus_write(2'd2, 32'd3);
        bus_write(2'd0, FULL | 32'h3);
        wait_running("rot_start");
        check("rot_0", 32'(out_port), 32'h81); check("rot_step0", bus.readdata, 32'h001);
        repeat (4) @(negedge clk); #1;
        check("rot_1", 32'(out_port), 32'h03); check("rot_step1", bus.readdata, 32'h101);
        repeat (4) @(negedge clk); #1;
        check("rot_2", 32'(out_port), 32'h06); check("rot_step2", bus.readdata, 32'h201);

        // BOUNCE, one step per clock
        bus_write(2'd0, FULL);
        bus_write(2'd1, 32'h01);
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, FULL | 32'h5);
        for (int i = 0; i < 8; i++) seq.push_back(8'(1 << i));
        for (int i = 6; i >= 0; i--) seq.push_back(8'(1 << i));
        seq.push_back(8'h02);
        wait_running("bnc_start");
        foreach (seq[i]) begin
            if (i != 0) begin @(negedge clk); #1; end
            check($sformatf("bnc_%0d", i), 32'(out_port), 32'(seq[i]));
        end

        // BLINK with disable landing on a tick
        bus_write(2'd0, FULL);
        bus_write(2'd1, 32'hA5);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, FULL | 32'h7);
        wait_running("blk_start");
        bus_write(2'd0, FULL | 32'h6);
        @(negedge clk); #1;
        check("blk_dis_out", 32'(out_port), 32'hA5);
        bus.address = 2'd3; #1;
        check("blk_dis_status", bus.readdata, 32'h0);

        // Asynchronous reset in RUN
        bus_write(2'd1, 32'h40);
        bus_write(2'd2, 32'd100);
        bus_write(2'd0, FULL | 32'h1);
        wait_running("ar_start");
        check("ar_pre", 32'(out_port), 32'h40);
        #2 reset = 1'b1;
        #1 check("ar_async", 32'(out_port), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        read_reg(2'd0, rd); check("ar_ctrl", rd, RST_CTRL);
        read_reg(2'd1, rd); check("ar_pattern", rd, 32'h0);
        read_reg(2'd2, rd); check("ar_period", rd, 32'h0);
        read_reg(2'd3, rd); check("ar_status", rd, 32'h0);

`ifdef LEDSEQ_PWM_EN
        bus_write(2'd1, 32'hFF);
        bus_write(2'd0, 32'h401);
        wait_running("pwm_start");
        on_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); #1;
            if (out_port == 8'hFF) on_cnt++;
        end
        check("pwm_b4", 32'(on_cnt), 32'd8);
        bus_write(2'd0, 32'hF01);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            if (out_port == 8'hFF) on_cnt++;
        end
        check("pwm_bF", 32'(on_cnt), 32'd16);
`endif

        // Randomised bus traffic against the model
        repeat (3000) begin
            @(posedge clk); #1;
            bus.address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                bus.chipselect = 1'b1; bus.write_n = 1'b0;
                case (bus.address)
                    2'd0: bus.writedata = ($urandom & 32'hFFFF_FFF8) |
                                          32'($urandom_range(0, 3) << 1) |
                                          32'($urandom_range(0, 3) != 0);
                    2'd1: case ($urandom_range(0, 3))
                              0: bus.writedata = 32'h0;
                              1: bus.writedata = 32'(1 << $urandom_range(0, LED_W - 1));
                              2: bus.writedata = 32'h81;
                              default: bus.writedata = $urandom;
                          endcase
                    2'd2: bus.writedata = 32'($urandom_range(0, 5));
                    default: bus.writedata = $urandom;
                endcase
            end else begin
                bus.chipselect = 1'($urandom_range(0, 1));
                bus.write_n    = bus.chipselect ? 1'b1 : 1'($urandom_range(0, 1));
                bus.writedata  = $urandom;
            end
        end
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
